// File: rtl/pipeline_halt_unit.sv
// Bubble/halt injector between decode and the Controller: inserts NOPs for
// control transfers, load-use hazards and debug halt, and counts stall cycles.
module pipeline_halt_unit #(
   parameter int               OPC_W        = 7,
   parameter int               REG_W        = 5,
   parameter int               CNT_W        = 3,
   parameter int               BR_BUBBLES   = 2,
   parameter int               JAL_BUBBLES  = 1,
   parameter int               JALR_BUBBLES = 2,
   parameter int               LD_BUBBLES   = 1,
   parameter logic [OPC_W-1:0] NOP_OPC      = 7'b0010011,
   parameter int               STAT_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [OPC_W-1:0]  id_opcode,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic              ex_memread,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              halt_req,
   output logic [OPC_W-1:0]  opcode_out,
   output logic              stall_if,
   output logic              bubble,
   output logic              halted,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [STAT_W-1:0] stall_cycles,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_HALT   = 2'd2
   } state_t;

   localparam logic [OPC_W-1:0] OPC_BR   = OPC_W'(7'b1100011);
   localparam logic [OPC_W-1:0] OPC_JAL  = OPC_W'(7'b1101111);
   localparam logic [OPC_W-1:0] OPC_JALR = OPC_W'(7'b1100111);

   localparam logic [CNT_W-1:0] BR_N      = CNT_W'(BR_BUBBLES);
   localparam logic [CNT_W-1:0] JAL_N     = CNT_W'(JAL_BUBBLES);
   localparam logic [CNT_W-1:0] JALR_N    = CNT_W'(JALR_BUBBLES);
   localparam logic [CNT_W-1:0] LD_RELOAD = CNT_W'(LD_BUBBLES - 1);
   localparam logic             LD_EN     = (LD_BUBBLES > 0);
   localparam logic             LD_MULTI  = (LD_BUBBLES > 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              lu_mode_q, lu_mode_d;
   logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic [CNT_W-1:0]  ctrl_n;
   logic              lu;

   always_comb begin
      ctrl_n = '0;
      case (id_opcode)
         OPC_BR:   ctrl_n = BR_N;
         OPC_JAL:  ctrl_n = JAL_N;
         OPC_JALR: ctrl_n = JALR_N;
         default:  ctrl_n = '0;
      endcase
   end

   assign lu = LD_EN & id_valid & ex_memread & (ex_rd != '0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lu_mode_d  = lu_mode_q;
      opcode_out = NOP_OPC;
      stall_if   = 1'b0;
      bubble     = 1'b0;
      halted     = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (halt_req) begin
               bubble   = 1'b1;
               stall_if = 1'b1;
               state_d  = ST_HALT;
            end else if (lu) begin
               // Single-bubble load-use stays in RUN so the held op re-checks next cycle.
               bubble   = 1'b1;
               stall_if = 1'b1;
               if (LD_MULTI) begin
                  cnt_d     = LD_RELOAD;
                  state_d   = ST_BUBBLE;
                  lu_mode_d = 1'b1;
               end
            end else if (id_valid && (ctrl_n != '0)) begin
               opcode_out = id_opcode;
               cnt_d      = ctrl_n;
               state_d    = ST_BUBBLE;
               lu_mode_d  = 1'b0;
            end else begin
               opcode_out = id_valid ? id_opcode : NOP_OPC;
               bubble     = ~id_valid;
            end
         end
         ST_BUBBLE: begin
            // Fetch keeps running down a redirected path unless this is a load-use wait.
            bubble   = 1'b1;
            stall_if = lu_mode_q;
            if (cnt_q <= CNT_W'(1)) begin
               state_d   = ST_RUN;
               cnt_d     = '0;
               lu_mode_d = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HALT: begin
            bubble   = 1'b1;
            stall_if = 1'b1;
            halted   = 1'b1;
            if (!halt_req) state_d = ST_RUN;
         end
         default: begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            lu_mode_d = 1'b0;
         end
      endcase

      if (!reset) begin
         opcode_out = NOP_OPC;
         stall_if   = 1'b0;
         bubble     = 1'b0;
         halted     = 1'b0;
      end

      stall_cycles_d = stall_cycles_q;
      if (bubble && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + STAT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_RUN;
         cnt_q          <= '0;
         lu_mode_q      <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         lu_mode_q      <= lu_mode_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign bubble_cnt   = cnt_q;
   assign stall_cycles = stall_cycles_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipeline_halt_unit.sv
// Directed bench for pipeline_halt_unit: default instance plus a re-parametrised
// one (JALR_BUBBLES=0, STAT_W=3) for the no-bubble and saturation cases.
module tb_pipeline_halt_unit;

   localparam logic [6:0] NOP  = 7'b0010011;
   localparam logic [6:0] ADD  = 7'b0110011;
   localparam logic [6:0] LUI  = 7'b0110111;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       reset2 = 1'b1;
   logic       id_valid = 1'b0;
   logic [6:0] id_opcode = '0;
   logic [4:0] id_rs1 = '0;
   logic [4:0] id_rs2 = '0;
   logic       ex_memread = 1'b0;
   logic [4:0] ex_rd = '0;
   logic       halt_req = 1'b0;

   logic [6:0]  opcode_out;
   logic        stall_if, bubble, halted;
   logic [2:0]  bubble_cnt;
   logic [31:0] stall_cycles;
   logic [1:0]  state_dbg;

   logic [6:0]  opcode_out2;
   logic        stall_if2, bubble2, halted2;
   logic [2:0]  bubble_cnt2;
   logic [2:0]  stall_cycles2;
   logic [1:0]  state_dbg2;

   int total = 0;
   int bad = 0;

   pipeline_halt_unit dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .halt_req(halt_req), .opcode_out(opcode_out), .stall_if(stall_if),
      .bubble(bubble), .halted(halted), .bubble_cnt(bubble_cnt),
      .stall_cycles(stall_cycles), .state_dbg(state_dbg)
   );

   pipeline_halt_unit #(.JALR_BUBBLES(0), .STAT_W(3)) dut2 (
      .clk(clk), .reset(reset2), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .halt_req(halt_req), .opcode_out(opcode_out2), .stall_if(stall_if2),
      .bubble(bubble2), .halted(halted2), .bubble_cnt(bubble_cnt2),
      .stall_cycles(stall_cycles2), .state_dbg(state_dbg2)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      id_valid = 1'b1; id_opcode = ADD;
      #1 reset = 1'b0; reset2 = 1'b0;
      repeat (3) tick;
      total++; if (opcode_out !== NOP) begin bad++; $display("FAIL rst_opcode got=%b exp=%b", opcode_out, NOP); end
      total++; if (stall_if !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_if); end
      total++; if (bubble !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL rst_bub_halt got=%b%b exp=00", bubble, halted); end
      total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_stat got=%0d exp=0", stall_cycles); end
      total++; if (bubble_cnt !== 3'd0 || state_dbg !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d/%0d exp=0/0", bubble_cnt, state_dbg); end
      reset = 1'b1;
      #1;
      total++; if (opcode_out !== ADD || bubble !== 1'b0) begin bad++; $display("FAIL rst_release got=%b/%b exp=%b/0", opcode_out, bubble, ADD); end
   endtask

   task automatic test_branch;
      tick; id_opcode = BR; #1;
      total++; if (opcode_out !== BR || bubble !== 1'b0 || stall_if !== 1'b0) begin bad++; $display("FAIL br_c0 got=%b/%b/%b exp=%b/0/0", opcode_out, bubble, stall_if, BR); end
      tick; id_opcode = LUI; #1;
      total++; if (opcode_out !== NOP || bubble !== 1'b1 || stall_if !== 1'b0 || bubble_cnt !== 3'd2) begin bad++; $display("FAIL br_c1 got=%b/%b/%b/%0d exp=%b/1/0/2", opcode_out, bubble, stall_if, bubble_cnt, NOP); end
      tick; #1;
      total++; if (opcode_out !== NOP || bubble !== 1'b1 || stall_if !== 1'b0 || bubble_cnt !== 3'd1) begin bad++; $display("FAIL br_c2 got=%b/%b/%b/%0d exp=%b/1/0/1", opcode_out, bubble, stall_if, bubble_cnt, NOP); end
      tick; #1;
      total++; if (opcode_out !== LUI || bubble !== 1'b0 || bubble_cnt !== 3'd0) begin bad++; $display("FAIL br_c3 got=%b/%b/%0d exp=%b/0/0", opcode_out, bubble, bubble_cnt, LUI); end
      total++; if (stall_cycles !== 32'd2) begin bad++; $display("FAIL br_stat got=%0d exp=2", stall_cycles); end
   endtask

   task automatic test_load_use;
      tick; id_opcode = ADD; id_rs1 = 5'd1; id_rs2 = 5'd5; ex_memread = 1'b1; ex_rd = 5'd5; #1;
      total++; if (opcode_out !== NOP || bubble !== 1'b1 || stall_if !== 1'b1) begin bad++; $display("FAIL lu_rs2 got=%b/%b/%b exp=%b/1/1", opcode_out, bubble, stall_if, NOP); end
      tick; ex_memread = 1'b0; #1;
      total++; if (opcode_out !== ADD || stall_if !== 1'b0 || stall_cycles !== 32'd3) begin bad++; $display("FAIL lu_resume got=%b/%b/%0d exp=%b/0/3", opcode_out, stall_if, stall_cycles, ADD); end
      tick; ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
      total++; if (opcode_out !== ADD || bubble !== 1'b0 || stall_if !== 1'b0) begin bad++; $display("FAIL lu_x0 got=%b/%b/%b exp=%b/0/0", opcode_out, bubble, stall_if, ADD); end
      tick; ex_rd = 5'd7; id_rs1 = 5'd7; #1;
      total++; if (stall_if !== 1'b1 || bubble !== 1'b1) begin bad++; $display("FAIL lu_rs1 got=%b/%b exp=1/1", stall_if, bubble); end
      tick; ex_memread = 1'b0; #1;
      total++; if (stall_if !== 1'b0 || bubble !== 1'b0 || stall_cycles !== 32'd4) begin bad++; $display("FAIL lu_nomem got=%b/%b/%0d exp=0/0/4", stall_if, bubble, stall_cycles); end
   endtask

   task automatic test_halt;
      tick; id_opcode = BR; #1;
      tick; id_opcode = ADD; #1;
      tick; halt_req = 1'b1; #1;
      total++; if (halted !== 1'b0 || stall_if !== 1'b0 || bubble !== 1'b1 || bubble_cnt !== 3'd1) begin bad++; $display("FAIL halt_defer got=%b/%b/%b/%0d exp=0/0/1/1", halted, stall_if, bubble, bubble_cnt); end
      tick; #1;
      total++; if (opcode_out !== NOP || stall_if !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL halt_entry got=%b/%b/%b exp=%b/1/0", opcode_out, stall_if, halted, NOP); end
      tick; #1;
      total++; if (halted !== 1'b1 || stall_if !== 1'b1 || state_dbg !== 2'd2) begin bad++; $display("FAIL halt_state got=%b/%b/%0d exp=1/1/2", halted, stall_if, state_dbg); end
      tick; halt_req = 1'b0; #1;
      total++; if (halted !== 1'b1 || bubble !== 1'b1) begin bad++; $display("FAIL halt_hold got=%b/%b exp=1/1", halted, bubble); end
      tick; #1;
      total++; if (halted !== 1'b0 || opcode_out !== ADD || bubble !== 1'b0) begin bad++; $display("FAIL halt_exit got=%b/%b/%b exp=0/%b/0", halted, opcode_out, bubble, ADD); end
      total++; if (stall_cycles !== 32'd9) begin bad++; $display("FAIL halt_stat got=%0d exp=9", stall_cycles); end
   endtask

   task automatic test_back_to_back;
      tick; id_opcode = JAL; #1;
      total++; if (opcode_out !== JAL || bubble !== 1'b0) begin bad++; $display("FAIL b2b_jal got=%b/%b exp=%b/0", opcode_out, bubble, JAL); end
      tick; id_opcode = JALR; #1;
      total++; if (opcode_out !== NOP || bubble_cnt !== 3'd1) begin bad++; $display("FAIL b2b_jal_bub got=%b/%0d exp=%b/1", opcode_out, bubble_cnt, NOP); end
      tick; #1;
      total++; if (opcode_out !== JALR || bubble !== 1'b0) begin bad++; $display("FAIL b2b_jalr got=%b/%b exp=%b/0", opcode_out, bubble, JALR); end
      tick; id_opcode = ADD; #1;
      total++; if (bubble !== 1'b1 || bubble_cnt !== 3'd2) begin bad++; $display("FAIL b2b_jalr_b1 got=%b/%0d exp=1/2", bubble, bubble_cnt); end
      tick; #1;
      tick; #1;
      total++; if (opcode_out !== ADD || bubble !== 1'b0) begin bad++; $display("FAIL b2b_after got=%b/%b exp=%b/0", opcode_out, bubble, ADD); end
      tick; id_opcode = BR; ex_memread = 1'b1; ex_rd = 5'd7; #1;
      total++; if (opcode_out !== NOP || stall_if !== 1'b1 || bubble_cnt !== 3'd0) begin bad++; $display("FAIL b2b_br_lu got=%b/%b/%0d exp=%b/1/0", opcode_out, stall_if, bubble_cnt, NOP); end
      tick; ex_memread = 1'b0; #1;
      total++; if (opcode_out !== BR || stall_if !== 1'b0) begin bad++; $display("FAIL b2b_br_issue got=%b/%b exp=%b/0", opcode_out, stall_if, BR); end
      tick; id_opcode = ADD; #1;
      total++; if (bubble !== 1'b1 || bubble_cnt !== 3'd2) begin bad++; $display("FAIL b2b_br_bub got=%b/%0d exp=1/2", bubble, bubble_cnt); end
      tick; #1;
      tick; id_valid = 1'b0; id_opcode = BR; #1;
      total++; if (opcode_out !== NOP || bubble !== 1'b1 || stall_if !== 1'b0) begin bad++; $display("FAIL b2b_invalid got=%b/%b/%b exp=%b/1/0", opcode_out, bubble, stall_if, NOP); end
      tick; id_valid = 1'b1; id_opcode = ADD; #1;
      total++; if (opcode_out !== ADD || bubble !== 1'b0) begin bad++; $display("FAIL b2b_invalid_ctrl got=%b/%b exp=%b/0", opcode_out, bubble, ADD); end
   endtask

   task automatic test_reset_mid_bubble;
      tick; id_opcode = BR; #1;
      tick; id_opcode = ADD; #1;
      tick; #1;
      total++; if (bubble_cnt !== 3'd1) begin bad++; $display("FAIL mid_pre got=%0d exp=1", bubble_cnt); end
      reset = 1'b0;
      #1;
      total++; if (state_dbg !== 2'd0 || bubble_cnt !== 3'd0 || bubble !== 1'b0 || opcode_out !== NOP) begin bad++; $display("FAIL mid_async got=%0d/%0d/%b/%b exp=0/0/0/%b", state_dbg, bubble_cnt, bubble, opcode_out, NOP); end
      total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL mid_stat got=%0d exp=0", stall_cycles); end
      tick; reset = 1'b1; #1;
      total++; if (opcode_out !== ADD || bubble !== 1'b0) begin bad++; $display("FAIL mid_release got=%b/%b exp=%b/0", opcode_out, bubble, ADD); end
      tick; #1;
      total++; if (bubble !== 1'b0 || state_dbg !== 2'd0) begin bad++; $display("FAIL mid_noleft got=%b/%0d exp=0/0", bubble, state_dbg); end
   endtask

   task automatic test_reparam;
      reset = 1'b0;
      tick; reset2 = 1'b1; id_valid = 1'b1; id_opcode = JALR; halt_req = 1'b0; ex_memread = 1'b0; #1;
      total++; if (opcode_out2 !== JALR || bubble2 !== 1'b0) begin bad++; $display("FAIL rp_jalr got=%b/%b exp=%b/0", opcode_out2, bubble2, JALR); end
      tick; id_opcode = ADD; #1;
      total++; if (opcode_out2 !== ADD || bubble2 !== 1'b0 || bubble_cnt2 !== 3'd0) begin bad++; $display("FAIL rp_jalr_next got=%b/%b/%0d exp=%b/0/0", opcode_out2, bubble2, bubble_cnt2, ADD); end
      tick; halt_req = 1'b1; #1;
      total++; if (bubble2 !== 1'b1) begin bad++; $display("FAIL rp_halt got=%b exp=1", bubble2); end
      repeat (6) tick;
      total++; if (stall_cycles2 !== 3'd6) begin bad++; $display("FAIL rp_stat6 got=%0d exp=6", stall_cycles2); end
      repeat (4) tick;
      total++; if (stall_cycles2 !== 3'd7) begin bad++; $display("FAIL rp_sat got=%0d exp=7", stall_cycles2); end
      halt_req = 1'b0;
      tick; tick;
      total++; if (halted2 !== 1'b0 || stall_cycles2 !== 3'd7) begin bad++; $display("FAIL rp_exit got=%b/%0d exp=0/7", halted2, stall_cycles2); end
   endtask

   initial begin
      test_reset;
      test_branch;
      test_load_use;
      test_halt;
      test_back_to_back;
      test_reset_mid_bubble;
      test_reparam;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_halt_unit.md
Name: pipeline_halt_unit

Overview:
Parametrised successor to the single-purpose halt logic between decode and the main Controller. It inserts NOP bubbles into the opcode stream fed to the Controller for three causes:
- control transfers (branch, JAL, JALR), with a programmable bubble count per class;
- load-use data hazards;
- an external debug halt request.
It also drives a fetch/decode stall and keeps a saturating count of stall cycles.

Parameters:
OPC_W, 7, opcode width
REG_W, 5, register index width
CNT_W, 3, bubble counter width
BR_BUBBLES, 2, bubbles after a conditional branch (0..2^CNT_W-1)
JAL_BUBBLES, 1, bubbles after JAL
JALR_BUBBLES, 2, bubbles after JALR
LD_BUBBLES, 1, bubbles for a load-use hazard
NOP_OPC, 7'b0010011, opcode injected as a bubble (ADDI x0,x0,0)
STAT_W, 32, stall statistics counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  decode stage holds a valid instruction
id_opcode  in  OPC_W  opcode in decode
id_rs1  in  REG_W  source register 1 in decode
id_rs2  in  REG_W  source register 2 in decode
ex_memread  in  1  execute stage instruction is a load
ex_rd  in  REG_W  execute stage destination register
halt_req  in  1  debug halt request, level sensitive
opcode_out  out  OPC_W  opcode to Controller
stall_if  out  1  hold PC and IF/ID register this cycle
bubble  out  1  opcode_out is an injected NOP
halted  out  1  unit is in HALT state
bubble_cnt  out  CNT_W  remaining bubbles
stall_cycles  out  STAT_W  saturating count of cycles with bubble=1

Behaviour:
- Opcode classes: BR=1100011, JAL=1101111, JALR=1100111. Any other opcode is non-control.
- Load-use hazard (combinational): lu = id_valid & ex_memread & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
- State is registered: RUN, BUBBLE, HALT. Outputs are a combinational decode of state plus inputs, so there is zero-cycle latency.
- While reset is low:
  - state=RUN, bubble_cnt=0, stall_cycles=0;
  - outputs forced to opcode_out=NOP_OPC, stall_if=0, bubble=0, halted=0.
- RUN, priority halt_req > lu > control > pass:
  - halt_req=1:
    - opcode_out=NOP, bubble=1, stall_if=1;
    - next state HALT.
  - lu=1:
    - opcode_out=NOP, bubble=1, stall_if=1;
    - if LD_BUBBLES>1: bubble_cnt<=LD_BUBBLES-1, next BUBBLE with stall_if held;
    - otherwise stay in RUN, and the held instruction is re-evaluated next cycle;
    - LD_BUBBLES=0 disables load-use detection entirely (pass).
  - id_valid and control class with N>0 bubbles:
    - opcode_out=id_opcode, bubble=0, stall_if=0;
    - bubble_cnt<=N, next BUBBLE.
  - Otherwise: opcode_out=id_opcode if id_valid, else NOP; bubble=~id_valid; stall_if=0.
- BUBBLE:
  - opcode_out=NOP, bubble=1, bubble_cnt decrements each cycle;
  - when bubble_cnt==1, next state is RUN with bubble_cnt<=0;
  - stall_if=1 only when BUBBLE was entered from load-use (tracked by a registered lu_mode flag), otherwise 0, so fetch proceeds down the redirected path;
  - halt_req is ignored until the return to RUN; it is deferred, never lost while still asserted.
- HALT:
  - opcode_out=NOP, bubble=1, stall_if=1, halted=1;
  - halt_req=0 gives next state RUN;
  - the instruction held in decode is re-evaluated in the first RUN cycle.
- stall_cycles increments on every clock edge with bubble=1 and saturates at all-ones, never wrapping.
- A control instruction that arrives while lu=1 is not counted as a control transfer until it issues.
- A reset mid-BUBBLE or mid-HALT returns to RUN immediately; the pending bubble count is discarded.

Test Plan:
- Reset low for 3 cycles with id_opcode=0110011 and id_valid=1 -> opcode_out=0010011, stall_if=0, stall_cycles=0. Release reset -> opcode_out=0110011 in the same cycle.
- BR (1100011) issued with BR_BUBBLES=2 -> cycle0 opcode_out=1100011; cycles1-2 NOP with bubble=1, stall_if=0; cycle3 passthrough; stall_cycles=2.
- Load-use with ex_memread=1, ex_rd=5, id_rs2=5 -> one NOP with stall_if=1. The same test with ex_rd=0 -> no bubble.
- halt_req asserted during the second BR bubble -> bubble completes first, then HALT (halted=1, stall_if=1) while halt_req=1. Deassert -> RUN next cycle.
- JALR with JALR_BUBBLES=0 (re-parametrised) -> no bubbles, passthrough. STAT_W=3 run with 10 bubbles -> stall_cycles saturates at 7.
- Assert reset mid-BUBBLE with bubble_cnt=1 -> state RUN and bubble_cnt=0 asynchronously, with no leftover NOP after release.
